irq_latch: RTL and testbench

Interrupt collection block between the free-running pulse sources (the `timer` match pulse and other one-cycle event strobes) and the CPU's exception logic. It captures single-cycle request pulses into sticky pending bits and applies a software mask. It presents one prioritized interrupt at a time on a level `irq` / `irq_id` pair, held until the CPU acknowledges it. Pulses that arrive while their line is already pending are counted as misses in per-line saturating counters.

---
 rtl/irq_latch_if.sv | 30 +++
 rtl/irq_latch.sv | 116 +++++++++++
 tb/tb_irq_latch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_latch_if.sv
// Bus between the interrupt collector and its CPU/event-source side.
interface irq_latch_if #(
    parameter int unsigned N_IRQ  = 8,
    parameter int unsigned ID_W   = 3,
    parameter int unsigned MISS_W = 4
);
    logic [N_IRQ-1:0]  req;
    logic              mask_we;
    logic [N_IRQ-1:0]  mask_in;
    logic [N_IRQ-1:0]  mask;
    logic [N_IRQ-1:0]  pending;
    logic              irq;
    logic [ID_W-1:0]   irq_id;
    logic              ack;
    logic [ID_W-1:0]   miss_sel;
    logic [MISS_W-1:0] miss_cnt;
    logic              miss_clr;

    // CPU / event-source side
    modport master (
        output req, mask_we, mask_in, ack, miss_sel, miss_clr,
        input  mask, pending, irq, irq_id, miss_cnt
    );

    // Interrupt collector side
    modport slave (
        input  req, mask_we, mask_in, ack, miss_sel, miss_clr,
        output mask, pending, irq, irq_id, miss_cnt
    );
endinterface

// File: rtl/irq_latch.sv
// Sticky interrupt collector: latches request pulses, masks them, reports the
// lowest-index eligible line as a held irq/irq_id pair until acknowledged,
// and counts pulses that land on an already-pending line.
module irq_latch #(
    parameter int unsigned N_IRQ  = 8,
    parameter int unsigned ID_W   = 3,
    parameter int unsigned MISS_W = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    irq_latch_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    state_e             state_q, state_d;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [MISS_W-1:0]  miss_q [N_IRQ];
    logic [MISS_W-1:0]  miss_d [N_IRQ];

    logic               ack_take;
    logic [N_IRQ-1:0]   clr_vec;
    logic [N_IRQ-1:0]   miss_inc;
    logic [N_IRQ-1:0]   eligible;

    // Pending capture, mask write and miss-counter next state
    always_comb begin
        ack_take = (state_q == StReq) && bus.ack;
        clr_vec  = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (ack_take && (irq_id_q == ID_W'(i))) clr_vec[i] = 1'b1;
        end
        // A pulse on the line being acknowledged re-sets it and is not a miss
        pending_d = (pending_q & ~clr_vec) | bus.req;
        miss_inc  = bus.req & pending_q & ~clr_vec;
        mask_d    = bus.mask_we ? bus.mask_in : mask_q;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            miss_d[i] = miss_q[i];
            if (bus.miss_clr && (bus.miss_sel == ID_W'(i))) begin
                miss_d[i] = MISS_W'(miss_inc[i]);
            end else if (miss_inc[i] && (miss_q[i] != '1)) begin
                miss_d[i] = miss_q[i] + 1'b1;
            end
        end
    end

    // Report FSM: pick lowest eligible line, hold until ack, one low gap cycle
    always_comb begin
        eligible = pending_q & mask_q;
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            StIdle: begin
                irq_d = 1'b0;
                if (|eligible) begin
                    irq_d   = 1'b1;
                    state_d = StReq;
                    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
                        if (eligible[i]) irq_id_d = ID_W'(i);
                    end
                end
            end
            StReq: begin
                if (bus.ack) begin
                    irq_d   = 1'b0;
                    state_d = StGap;
                end
            end
            StGap: begin
                irq_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            for (int i = 0; i < int'(N_IRQ); i++) miss_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            for (int i = 0; i < int'(N_IRQ); i++) miss_q[i] <= miss_d[i];
        end
    end

    // Combinational miss readout; unselectable indices read zero
    always_comb begin
        bus.miss_cnt = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (bus.miss_sel == ID_W'(i)) bus.miss_cnt = miss_q[i];
        end
    end

    assign bus.mask    = mask_q;
    assign bus.pending = pending_q;
    assign bus.irq     = irq_q;
    assign bus.irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_latch.sv
// Bench for irq_latch: directed vector table, miss-counter sequence, then
// random traffic against a behavioural model.
module tb_irq_latch;
    localparam int N    = 8;
    localparam int IDW  = 3;
    localparam int MW   = 4;
    localparam int MMAX = (1 << MW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_latch_if #(.N_IRQ(N), .ID_W(IDW), .MISS_W(MW)) bus ();

    irq_latch #(.N_IRQ(N), .ID_W(IDW), .MISS_W(MW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         we;
        logic [N-1:0] min;
        logic         ack;
        logic [2:0]   sel;
        logic         clr;
        logic         e_irq;
        logic [2:0]   e_id;
        logic [N-1:0] e_pend;
        logic [N-1:0] e_mask;
        logic [3:0]   e_miss;
    } vec_t;

    vec_t tab[$];
    int   nvec = 0;
    int   nerr = 0;

    // Behavioural model: sticky set, one report in flight, quiet cycles after ack
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_mask = '0;
    int           m_miss [N];
    bit           m_active = 1'b0;
    int           m_id = 0;
    int           m_quiet = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] clrv;
        logic [N-1:0] inc;
        logic [N-1:0] elig;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_active = 1'b0; m_id = 0; m_quiet = 0;
            for (int i = 0; i < N; i++) m_miss[i] = 0;
            return;
        end
        clrv = '0;
        if (m_active && bus.ack) clrv[m_id] = 1'b1;
        inc = bus.req & m_pend & ~clrv;
        for (int i = 0; i < N; i++) begin
            if (bus.miss_clr && (int'(bus.miss_sel) == i)) m_miss[i] = inc[i] ? 1 : 0;
            else if (inc[i] && m_miss[i] < MMAX) m_miss[i] = m_miss[i] + 1;
        end
        elig = m_pend & m_mask;
        if (m_active) begin
            if (bus.ack) begin
                m_active = 1'b0;
                m_quiet  = 1;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (elig != '0) begin
            m_active = 1'b1;
            m_id = 0;
            while (!elig[m_id]) m_id++;
        end
        m_pend = (m_pend & ~clrv) | bus.req;
        if (bus.mask_we) m_mask = bus.mask_in;
    endtask

    task automatic model_check(input string tag);
        chk({tag, " irq"}, int'(bus.irq), int'(m_active));
        if (m_active) chk({tag, " irq_id"}, int'(bus.irq_id), m_id);
        chk({tag, " pending"}, int'(bus.pending), int'(m_pend));
        chk({tag, " mask"}, int'(bus.mask), int'(m_mask));
        chk({tag, " miss_cnt"}, int'(bus.miss_cnt), m_miss[bus.miss_sel]);
    endtask

    // Apply one cycle of inputs, advance model and DUT, compare outputs
    task automatic drive(input logic r, input logic [N-1:0] rq, input logic we,
                         input logic [N-1:0] mi, input logic ak, input logic [2:0] sl,
                         input logic cl, input string tag);
        rst = r; bus.req = rq; bus.mask_we = we; bus.mask_in = mi;
        bus.ack = ak; bus.miss_sel = sl; bus.miss_clr = cl;
        model_step();
        @(posedge clk);
        #1;
        model_check(tag);
    endtask

    task automatic add(input logic r, input logic [N-1:0] rq, input logic we,
                       input logic [N-1:0] mi, input logic ak, input logic [2:0] sl,
                       input logic cl, input logic ei, input logic [2:0] eid,
                       input logic [N-1:0] ep, input logic [N-1:0] em, input logic [3:0] ems);
        vec_t v;
        v.rst = r; v.req = rq; v.we = we; v.min = mi; v.ack = ak; v.sel = sl; v.clr = cl;
        v.e_irq = ei; v.e_id = eid; v.e_pend = ep; v.e_mask = em; v.e_miss = ems;
        tab.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_miss[i] = 0;
        bus.req = '0; bus.mask_we = 1'b0; bus.mask_in = '0; bus.ack = 1'b0;
        bus.miss_sel = '0; bus.miss_clr = 1'b0;

        //  rst req  we min  ack sel clr | irq id pend  mask  miss
        // single pulse on line 0
        add(1, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 8'h01, 0, 0, 0,   0, 0, 8'h00, 8'h01, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, 0,   0, 0, 8'h01, 8'h01, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   1, 0, 8'h01, 8'h01, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   1, 0, 8'h01, 8'h01, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 8'h01, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 8'h01, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 8'h01, 0);
        // priority and freeze
        add(0, 8'h28, 1, 8'hFF, 0, 0, 0,   0, 0, 8'h28, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   1, 3, 8'h28, 8'hFF, 0);
        add(0, 8'h01, 0, 8'h00, 0, 0, 0,   1, 3, 8'h29, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 8'h21, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h21, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   1, 0, 8'h21, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 8'h20, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h20, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   1, 5, 8'h20, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 8'hFF, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 8'hFF, 0);
        // masked line still latches; mask write releases it two cycles later
        add(0, 8'h00, 1, 8'h00, 0, 0, 0,   0, 0, 8'h00, 8'h00, 0);
        add(0, 8'h04, 0, 8'h00, 0, 0, 0,   0, 0, 8'h04, 8'h00, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 8'h04, 8'h00, 0);
        add(0, 8'h00, 1, 8'h04, 0, 0, 0,   0, 0, 8'h04, 8'h04, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0,   1, 2, 8'h04, 8'h04, 0);
        // ack/req collision on line 4, then a real miss, then reset mid-REQ
        add(0, 8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 8'h00, 8'h04, 0);
        add(0, 8'h00, 1, 8'h10, 0, 0, 0,   0, 0, 8'h00, 8'h10, 0);
        add(0, 8'h10, 0, 8'h00, 0, 0, 0,   0, 0, 8'h10, 8'h10, 0);
        add(0, 8'h00, 0, 8'h00, 0, 4, 0,   1, 4, 8'h10, 8'h10, 0);
        add(0, 8'h10, 0, 8'h00, 1, 4, 0,   0, 0, 8'h10, 8'h10, 0);
        add(0, 8'h00, 0, 8'h00, 0, 4, 0,   0, 0, 8'h10, 8'h10, 0);
        add(0, 8'h00, 0, 8'h00, 0, 4, 0,   1, 4, 8'h10, 8'h10, 0);
        add(0, 8'h12, 0, 8'h00, 0, 4, 0,   1, 4, 8'h12, 8'h10, 1);
        add(1, 8'h08, 0, 8'h00, 0, 4, 0,   0, 0, 8'h00, 8'h00, 0);
        add(0, 8'h00, 0, 8'h00, 0, 4, 0,   0, 0, 8'h00, 8'h00, 0);

        foreach (tab[k]) begin
            string tg;
            tg = $sformatf("row%0d", k);
            drive(tab[k].rst, tab[k].req, tab[k].we, tab[k].min, tab[k].ack,
                  tab[k].sel, tab[k].clr, tg);
            chk({tg, " tab irq"}, int'(bus.irq), int'(tab[k].e_irq));
            if (tab[k].e_irq || tab[k].rst) chk({tg, " tab irq_id"}, int'(bus.irq_id), int'(tab[k].e_id));
            chk({tg, " tab pending"}, int'(bus.pending), int'(tab[k].e_pend));
            chk({tg, " tab mask"}, int'(bus.mask), int'(tab[k].e_mask));
            chk({tg, " tab miss"}, int'(bus.miss_cnt), int'(tab[k].e_miss));
        end

        // miss saturation, clear, and clear-with-increment
        drive(1, 8'h00, 0, 8'h00, 0, 1, 0, "miss rst");
        for (int i = 0; i < 20; i++) drive(0, 8'h02, 0, 8'h00, 0, 1, 0, "miss pulse");
        chk("miss saturated", int'(bus.miss_cnt), 15);
        drive(0, 8'h00, 0, 8'h00, 0, 1, 1, "miss clr");
        chk("miss cleared", int'(bus.miss_cnt), 0);
        drive(0, 8'h02, 0, 8'h00, 0, 1, 1, "miss clr+inc");
        chk("miss clr with pulse", int'(bus.miss_cnt), 1);

        // random traffic against the model
        drive(1, 8'h00, 0, 8'h00, 0, 0, 0, "rnd rst");
        for (int c = 0; c < 3000; c++) begin
            logic         r;
            logic [N-1:0] rq;
            r  = ($urandom_range(0, 199) == 0);
            rq = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            drive(r, rq, ($urandom_range(0, 7) == 0), N'($urandom),
                  ($urandom_range(0, 2) == 0), 3'($urandom_range(0, N - 1)),
                  ($urandom_range(0, 15) == 0), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
